shift_capture_rx: RTL and testbench
===================================

// Module: shift_capture_rx
// PURPOSE
//  Receiving end of the register unit's serial shift path. Samples the serial bits
//  (A_out/B_out) that leave registers A and B on each Shift_En cycle of an Execute,
//  and reassembles them into parallel words. Presents the words with a Valid/Ack
//  handshake plus error flags, so SignalTap and the bench can check each shift burst.
// PARAMETERS
//  WIDTH     8   bits per burst (register width; 4 for the nibble build)
//  CNT_W     8   width of Word_Count
// PORTS
//  Clk         in   1        system clock, all logic on rising edge
//  Reset       in   1        synchronous, active-low reset
//  Shift_En    in   1        from control unit: high = one serial bit on A_In/B_In
//  A_In        in   1        serial bit shifted out of register A (LSB first)
//  B_In        in   1        serial bit shifted out of register B (LSB first)
//  Ack         in   1        consumer accepts the held words
//  Valid       out  1        A_Word/B_Word hold a complete burst
//  A_Word      out  WIDTH    reassembled A value
//  B_Word      out  WIDTH    reassembled B value
//  Busy        out  1        burst capture in progress
//  Frame_Err   out  1        one-cycle pulse: burst ended short of WIDTH bits
//  Overrun     out  1        sticky: a burst arrived while Valid was pending
//  Word_Count  out  CNT_W    number of completed bursts, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (Reset==0 at a rising edge) forces IDLE and sets every output to 0.
//  It overrides every other input and aborts any capture in progress.
//  States: IDLE, SHIFT, HOLD.
//  - IDLE: when Shift_En=1, sample bit 0 and go to SHIFT with bit count=1. Busy=1
//    from the next cycle.
//  - SHIFT: each cycle with Shift_En=1, shift the bit in at the MSB, shifting the
//    shadow register right, so the first bit received lands in bit 0.
//    After the WIDTH-th bit, copy the shadow registers to A_Word/B_Word,
//    increment Word_Count, and go to HOLD.
//    Valid=1 in the cycle after the last sampled bit (latency 1). Busy drops in the same cycle.
//  - SHIFT with Shift_En=0 before WIDTH bits (gap): discard the partial data, pulse
//    Frame_Err for 1 cycle, and return to IDLE. A_Word, B_Word and Word_Count are unchanged.
//  - HOLD: Valid=1 and the words are stable. Ack=1 clears Valid at the next edge and
//    moves to IDLE.
//    Shift_En=1 in HOLD without Ack: set Overrun (sticky until reset). The burst is
//    ignored in its entirety; remain in HOLD.
//    Ack=1 and Shift_En=1 in the same HOLD cycle: the Ack is honoured and that
//    Shift_En bit is captured as bit 0 of a new burst (go to SHIFT, count=1).
//  - Ack is ignored outside HOLD.
//  - WIDTH=1: a single Shift_En cycle completes a burst (IDLE -> HOLD directly).
//  - Word_Count wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
//  1. Reset=0 for 2 cycles -> all outputs 0. Release reset, hold Shift_En=0 for 10
//     cycles -> outputs stay 0.
//  2. 8 consecutive Shift_En cycles with A bits 0,1,0,1,1,0,1,0 and B bits
//     1,1,1,1,0,0,0,0 -> one cycle after the last bit: Valid=1, A_Word=0x5A,
//     B_Word=0x0F, Word_Count=1. Ack -> Valid=0 next cycle.
//  3. Drop Shift_En after 5 bits -> Frame_Err high for exactly 1 cycle, Valid stays 0,
//     Word_Count unchanged, and a following full burst of 0xFF/0x00 captures correctly.
//  4. With Valid pending and no Ack, send a second burst -> Overrun=1, A_Word and
//     B_Word keep the first values. Ack -> Valid=0 and Overrun stays 1.
//  5. Ack in the same cycle as the first bit of the next burst -> the new burst is
//     captured completely (A=0xC3 -> A_Word=0xC3), and Overrun stays 0.
//  6. Assert Reset=0 during bit 4 of a burst -> IDLE, all outputs 0. Then 256 good
//     bursts -> Word_Count wraps to 0.

Source files
------------

// File: rtl/shift_capture_rx.sv
// Serial-to-parallel capture for the A/B register shift path.
// Reassembles LSB-first bursts and holds them under a Valid/Ack handshake.
module shift_capture_rx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Shift_En,
   input  logic             A_In,
   input  logic             B_In,
   input  logic             Ack,
   output logic             Valid,
   output logic [WIDTH-1:0] A_Word,
   output logic [WIDTH-1:0] B_Word,
   output logic             Busy,
   output logic             Frame_Err,
   output logic             Overrun,
   output logic [CNT_W-1:0] Word_Count
);

   localparam int unsigned BCW = $clog2(WIDTH + 1);
   localparam int unsigned SW  = (WIDTH > 1) ? WIDTH - 1 : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [WIDTH-1:0] a_word_q, a_word_d, b_word_q, b_word_d;
   logic [WIDTH-1:0] a_shifted, b_shifted;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             drop_q, drop_d;
   logic             start, take, last;

   // Shadow keeps only the bits received so far; the incoming bit completes the word.
   if (WIDTH > 1) begin : g_shadow
      assign a_shifted = {A_In, a_sh_q};
      assign b_shifted = {B_In, b_sh_q};
      assign a_sh_d    = (start || take) ? a_shifted[WIDTH-1:1] : a_sh_q;
      assign b_sh_d    = (start || take) ? b_shifted[WIDTH-1:1] : b_sh_q;
   end else begin : g_single
      assign a_shifted = A_In;
      assign b_shifted = B_In;
      assign a_sh_d    = a_sh_q;
      assign b_sh_d    = b_sh_q;
   end

   // drop_q swallows the rest of a burst that began while a word was still pending.
   assign start = Shift_En && !drop_q && ((state_q == IDLE) || ((state_q == HOLD) && Ack));
   assign take  = Shift_En && (state_q == SHIFT);
   assign last  = (start && (WIDTH == 1)) || (take && (bit_cnt_q == BCW'(WIDTH - 1)));

   always_ff @(posedge Clk) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = last ? HOLD : SHIFT;
         SHIFT:   if (!Shift_En) state_d = IDLE;
                  else if (last) state_d = HOLD;
         HOLD:    if (Ack) state_d = start ? (last ? HOLD : SHIFT) : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d   = start ? BCW'(1) : (take ? bit_cnt_q + BCW'(1) : bit_cnt_q);
      a_word_d    = last ? a_shifted : a_word_q;
      b_word_d    = last ? b_shifted : b_word_q;
      count_d     = last ? count_q + CNT_W'(1) : count_q;
      frame_err_d = (state_q == SHIFT) && !Shift_En;
      overrun_d   = overrun_q || ((state_q == HOLD) && Shift_En && !Ack);
      drop_d      = Shift_En && (drop_q || ((state_q == HOLD) && !Ack));
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         a_word_q    <= '0;
         b_word_q    <= '0;
         bit_cnt_q   <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         a_word_q    <= a_word_d;
         b_word_q    <= b_word_d;
         bit_cnt_q   <= bit_cnt_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      Valid      = (state_q == HOLD);
      Busy       = (state_q == SHIFT);
      A_Word     = a_word_q;
      B_Word     = b_word_q;
      Frame_Err  = frame_err_q;
      Overrun    = overrun_q;
      Word_Count = count_q;
   end

endmodule

// File: tb/tb_shift_capture_rx.sv
// Directed bench for shift_capture_rx: scoreboarded bursts, gaps, overrun, ack overlap, reset, wrap.
module tb_shift_capture_rx;

   logic       Clk = 1'b0;
   logic       Reset, Shift_En, A_In, B_In, Ack;
   logic       Valid, Busy, Frame_Err, Overrun;
   logic [7:0] A_Word, B_Word, Word_Count;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] exp_cnt;
   int         vectors = 0;
   int         miscompares = 0;

   shift_capture_rx #(.WIDTH(8), .CNT_W(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Shift_En   (Shift_En),
      .A_In       (A_In),
      .B_In       (B_In),
      .Ack        (Ack),
      .Valid      (Valid),
      .A_Word     (A_Word),
      .B_Word     (B_Word),
      .Busy       (Busy),
      .Frame_Err  (Frame_Err),
      .Overrun    (Overrun),
      .Word_Count (Word_Count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, 32'(Valid), 32'd0);
      check({tag, "_busy"}, 32'(Busy), 32'd0);
      check({tag, "_ferr"}, 32'(Frame_Err), 32'd0);
      check({tag, "_ovr"}, 32'(Overrun), 32'd0);
      check({tag, "_awd"}, 32'(A_Word), 32'd0);
      check({tag, "_bwd"}, 32'(B_Word), 32'd0);
      check({tag, "_cnt"}, 32'(Word_Count), 32'd0);
   endtask

   // Drives nbits serial bits; Ack is raised together with the first bit when ack_first is set.
   task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int nbits,
                            input bit ack_first);
      for (int i = 0; i < nbits; i++) begin
         Shift_En = 1'b1;
         A_In     = a[i];
         B_In     = b[i];
         Ack      = (i == 0) && ack_first;
         tick();
         Ack      = 1'b0;
      end
      Shift_En = 1'b0;
      A_In     = 1'b0;
      B_In     = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.a   = a;
      e.b   = b;
      e.cnt = exp_cnt;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, "_valid"}, 32'(Valid), 32'd1);
      check({tag, "_busy"}, 32'(Busy), 32'd0);
      if (sb_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_awd"}, 32'(A_Word), 32'(e.a));
         check({tag, "_bwd"}, 32'(B_Word), 32'(e.b));
         check({tag, "_cnt"}, 32'(Word_Count), 32'(e.cnt));
      end
   endtask

   task automatic do_ack();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      Reset = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      Reset   = 1'b1;
      exp_cnt = 8'd0;
      sb_q.delete();
   endtask

   initial begin
      logic [7:0] ra, rb;
      Reset = 1'b0; Shift_En = 1'b0; A_In = 1'b0; B_In = 1'b0; Ack = 1'b0;
      exp_cnt = 8'd0;

      // 1: reset and quiet line
      do_reset(2);
      check_idle_zero("rst");
      for (int i = 0; i < 10; i++) tick();
      check_idle_zero("quiet");

      // 2: basic burst A=0x5A B=0x0F
      push_exp(8'h5A, 8'h0F);
      send_bits(8'h5A, 8'h0F, 1, 1'b0);
      check("t2_busy_first", 32'(Busy), 32'd1);
      check("t2_valid_first", 32'(Valid), 32'd0);
      send_bits(8'h5A >> 1, 8'h0F >> 1, 7, 1'b0);
      pop_check("t2");
      do_ack();
      check("t2_ack_valid", 32'(Valid), 32'd0);

      // 3: short burst then a good one
      send_bits(8'h15, 8'h0A, 5, 1'b0);
      check("t3_ferr_pre", 32'(Frame_Err), 32'd0);
      check("t3_busy_pre", 32'(Busy), 32'd1);
      tick();
      check("t3_ferr", 32'(Frame_Err), 32'd1);
      check("t3_valid", 32'(Valid), 32'd0);
      check("t3_cnt", 32'(Word_Count), 32'd1);
      check("t3_awd", 32'(A_Word), 32'h5A);
      tick();
      check("t3_ferr_drop", 32'(Frame_Err), 32'd0);
      push_exp(8'hFF, 8'h00);
      send_bits(8'hFF, 8'h00, 8, 1'b0);
      pop_check("t3_full");

      // 4: overrun while a word is pending
      do_ack();
      push_exp(8'h12, 8'h34);
      send_bits(8'h12, 8'h34, 8, 1'b0);
      pop_check("t4_first");
      send_bits(8'h99, 8'h66, 1, 1'b0);
      check("t4_ovr_set", 32'(Overrun), 32'd1);
      send_bits(8'h99 >> 1, 8'h66 >> 1, 7, 1'b0);
      check("t4_valid_hold", 32'(Valid), 32'd1);
      check("t4_awd_kept", 32'(A_Word), 32'h12);
      check("t4_bwd_kept", 32'(B_Word), 32'h34);
      check("t4_cnt_kept", 32'(Word_Count), 32'd3);
      do_ack();
      check("t4_ack_valid", 32'(Valid), 32'd0);
      check("t4_ovr_sticky", 32'(Overrun), 32'd1);
      tick();
      check("t4_no_capture", 32'(Busy), 32'd0);

      // 5: Ack coincident with first bit of the next burst
      do_reset(1);
      push_exp(8'h3C, 8'h11);
      send_bits(8'h3C, 8'h11, 8, 1'b0);
      pop_check("t5_first");
      push_exp(8'hC3, 8'hA5);
      send_bits(8'hC3, 8'hA5, 1, 1'b1);
      check("t5_ack_valid", 32'(Valid), 32'd0);
      check("t5_ack_busy", 32'(Busy), 32'd1);
      send_bits(8'hC3 >> 1, 8'hA5 >> 1, 7, 1'b0);
      pop_check("t5_second");
      check("t5_ovr", 32'(Overrun), 32'd0);
      do_ack();

      // 6: reset during bit 4, then 256 bursts wrap the counter
      send_bits(8'h07, 8'h01, 3, 1'b0);
      Shift_En = 1'b1;
      A_In     = 1'b1;
      Reset    = 1'b0;
      tick();
      Shift_En = 1'b0;
      A_In     = 1'b0;
      check_idle_zero("t6_rst");
      do_reset(1);
      for (int n = 0; n < 256; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         push_exp(ra, rb);
         send_bits(ra, rb, 8, 1'b0);
         pop_check("t6_burst");
         do_ack();
      end
      check("t6_wrap", 32'(Word_Count), 32'd0);
      check("t6_valid_end", 32'(Valid), 32'd0);
      check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
